// File: rtl/multicycle_alu.sv
// Execution-stage ALU: single-cycle arithmetic/logic ops plus bit-serial shifts and a
// shift-add multiplier, all behind one start/done handshake with registered flags.
module multicycle_alu #(
  parameter int WIDTH = 32,
  parameter int OP_W  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             overflow_flag,
  output logic             illegal_op
);

  localparam logic [OP_W-1:0] OpAdd = 4'd0;
  localparam logic [OP_W-1:0] OpSub = 4'd1;
  localparam logic [OP_W-1:0] OpAnd = 4'd2;
  localparam logic [OP_W-1:0] OpOr  = 4'd3;
  localparam logic [OP_W-1:0] OpXor = 4'd4;
  localparam logic [OP_W-1:0] OpSlt = 4'd5;
  localparam logic [OP_W-1:0] OpSll = 4'd6;
  localparam logic [OP_W-1:0] OpSrl = 4'd7;
  localparam logic [OP_W-1:0] OpSra = 4'd8;
  localparam logic [OP_W-1:0] OpMul = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;

  logic [WIDTH-1:0] sum, diff, finRes;
  logic             finOvf, finIll, isShift;

  assign sum     = a_q + b_q;
  assign diff    = a_q - b_q;
  assign isShift = (op == OpSll) || (op == OpSrl) || (op == OpSra);

  // Final value of the latched op; a_q holds the shifted word, acc_q the product.
  always_comb begin
    finRes = '0;
    finOvf = 1'b0;
    finIll = 1'b0;
    case (op_q)
      OpAdd: begin
        finRes = sum;
        finOvf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpSub: begin
        finRes = diff;
        finOvf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpAnd: finRes = a_q & b_q;
      OpOr:  finRes = a_q | b_q;
      OpXor: finRes = a_q ^ b_q;
      OpSlt: finRes = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OpSll, OpSrl, OpSra: finRes = a_q;
      OpMul: finRes = acc_q;
      default: finIll = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          a_d    = operand_a;
          b_d    = operand_b;
          acc_d  = '0;
          busy_d = 1'b1;
          if (isShift && (operand_b[4:0] != 5'd0)) begin
            state_d = EXEC;
            cnt_d   = {1'b0, operand_b[4:0]};
          end else if (op == OpMul) begin
            state_d = EXEC;
            cnt_d   = 6'd32;
          end else begin
            state_d = DONE;
            cnt_d   = 6'd0;
          end
        end
      end
      EXEC: begin
        case (op_q)
          OpSll: a_d = {a_q[WIDTH-2:0], 1'b0};
          OpSrl: a_d = {1'b0, a_q[WIDTH-1:1]};
          OpSra: a_d = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
          default: begin
            if (b_q[0]) acc_d = acc_q + a_q;
            a_d = {a_q[WIDTH-2:0], 1'b0};
            b_d = {1'b0, b_q[WIDTH-1:1]};
          end
        endcase
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = DONE;
      end
      DONE: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        result_d = finRes;
        zero_d   = (finRes == '0);
        ovf_d    = finOvf;
        ill_d    = finIll;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign zero_flag     = zero_q;
  assign overflow_flag = ovf_q;
  assign illegal_op    = ill_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: directed scenarios plus random ops, with expected
// values and latencies computed by a plain-arithmetic reference model.
module tb_multicycle_alu;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero_flag;
  logic        overflow_flag;
  logic        illegal_op;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        v;
    logic        ill;
    int          lat;
    int          issue;
  } exp_t;

  exp_t sbQ[$];
  int   cyc = 0;
  int   checksTotal = 0;
  int   checksPassed = 0;

  multicycle_alu #(.WIDTH(32), .OP_W(4)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .op(op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .busy(busy),
    .done(done),
    .result(result),
    .zero_flag(zero_flag),
    .overflow_flag(overflow_flag),
    .illegal_op(illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count rising edges so latency can be measured in edges from start acceptance.
  always @(posedge clock) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checksTotal++;
    if (act === exp) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference behaviour from the op definitions, using wide signed arithmetic for overflow.
  function automatic exp_t refModel(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint sa, sb, s;
    longint unsigned p;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    e.res = 32'd0;
    e.v = 1'b0;
    e.ill = 1'b0;
    e.lat = 1;
    e.issue = 0;
    case (o)
      4'd0: begin s = sa + sb; e.res = a + b; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd1: begin s = sa - sb; e.res = a - b; e.v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      4'd2: e.res = a & b;
      4'd3: e.res = a | b;
      4'd4: e.res = a ^ b;
      4'd5: e.res = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: begin e.res = a << sh; e.lat = (sh == 0) ? 1 : sh + 1; end
      4'd7: begin e.res = a >> sh; e.lat = (sh == 0) ? 1 : sh + 1; end
      4'd8: begin e.res = $signed(a) >>> sh; e.lat = (sh == 0) ? 1 : sh + 1; end
      4'd9: begin p = 64'(a) * 64'(b); e.res = p[31:0]; e.lat = 33; end
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  // Issue one op, wait (bounded) for its done, then leave one idle cycle.
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit seen;
    @(negedge clock);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    e = refModel(o, a, b);
    e.issue = cyc + 1;
    sbQ.push_back(e);
    @(negedge clock);
    start = 1'b0;
    op = 4'($urandom); operand_a = $urandom; operand_b = $urandom;
    seen = done;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      seen = done;
    end
    if (!seen) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
      if (sbQ.size() > 0) void'(sbQ.pop_front());
    end
    @(negedge clock);
  endtask

  // Monitor: every done pops the oldest expectation and compares values and latency.
  always @(negedge clock) begin
    exp_t e;
    if (done) begin
      if (sbQ.size() == 0) begin
        checkOutput("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("result", result, e.res);
        checkOutput("zero_flag", 32'(zero_flag), 32'(e.z));
        checkOutput("overflow_flag", 32'(overflow_flag), 32'(e.v));
        checkOutput("illegal_op", 32'(illegal_op), 32'(e.ill));
        checkOutput("latency", 32'(cyc - e.issue), 32'(e.lat));
      end
    end else if (illegal_op) begin
      checkOutput("illegal_without_done", 32'(illegal_op), 32'd0);
    end
  end

  initial begin
    exp_t e;
    int k;
    bit seen;
    reset = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_zero", 32'(zero_flag), 32'd0);
    checkOutput("reset_ovf", 32'(overflow_flag), 32'd0);
    checkOutput("reset_illegal", 32'(illegal_op), 32'd0);

    applyStimulus(4'd0, 32'd5, 32'd7);
    checkOutput("post_done_low", 32'(done), 32'd0);
    checkOutput("post_busy_low", 32'(busy), 32'd0);
    applyStimulus(4'd1, 32'h8000_0000, 32'd1);
    applyStimulus(4'd1, 32'd9, 32'd9);
    applyStimulus(4'd0, 32'h7FFF_FFFF, 32'd1);

    // SRA by 4: busy must already be up in the cycle after acceptance.
    @(negedge clock);
    op = 4'd8; operand_a = 32'h8000_0010; operand_b = 32'd4; start = 1'b1;
    e = refModel(4'd8, 32'h8000_0010, 32'd4); e.issue = cyc + 1; sbQ.push_back(e);
    @(negedge clock);
    start = 1'b0;
    checkOutput("sra_busy", 32'(busy), 32'd1);
    seen = done;
    for (int i = 0; i < 40 && !seen; i++) begin @(negedge clock); seen = done; end
    if (!seen) begin checkOutput("done_timeout", 32'd0, 32'd1); if (sbQ.size() > 0) void'(sbQ.pop_front()); end
    @(negedge clock);

    applyStimulus(4'd6, 32'hDEAD_BEEF, 32'd0);
    applyStimulus(4'd7, 32'h8000_0000, 32'd31);
    applyStimulus(4'd5, 32'hFFFF_FFFF, 32'd1);
    applyStimulus(4'd5, 32'd1, 32'hFFFF_FFFF);
    applyStimulus(4'd12, 32'h1234_5678, 32'h9ABC_DEF0);

    // MUL with a stray start at edge 10 of the op, which must be ignored.
    @(negedge clock);
    op = 4'd9; operand_a = 32'hFFFF_FFFF; operand_b = 32'd3; start = 1'b1;
    e = refModel(4'd9, 32'hFFFF_FFFF, 32'd3); e.issue = cyc + 1; sbQ.push_back(e);
    k = cyc + 1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 20 && cyc < k + 9; i++) @(negedge clock);
    op = 4'd0; operand_a = 32'd100; operand_b = 32'd200; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("mul_busy", 32'(busy), 32'd1);
    seen = done;
    for (int i = 0; i < 40 && !seen; i++) begin @(negedge clock); seen = done; end
    if (!seen) begin checkOutput("done_timeout", 32'd0, 32'd1); if (sbQ.size() > 0) void'(sbQ.pop_front()); end
    repeat (5) @(negedge clock);

    // Reset at edge 15 of a MUL aborts it with no done pulse.
    op = 4'd9; operand_a = 32'h0001_0001; operand_b = 32'd77; start = 1'b1;
    e = refModel(4'd9, 32'h0001_0001, 32'd77); e.issue = cyc + 1; sbQ.push_back(e);
    k = cyc + 1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 20 && cyc < k + 14; i++) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    if (sbQ.size() > 0) void'(sbQ.pop_front());
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_result", result, 32'd0);
    checkOutput("abort_zero", 32'(zero_flag), 32'd0);
    checkOutput("abort_ovf", 32'(overflow_flag), 32'd0);
    repeat (40) @(negedge clock);
    applyStimulus(4'd0, 32'd1, 32'd1);

    for (int n = 0; n < 60; n++) begin
      logic [3:0] ro;
      logic [31:0] ra, rb;
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rb = $urandom;
      if (n % 4 == 0) rb = ra;
      applyStimulus(ro, ra, rb);
    end

    repeat (5) @(negedge clock);
    checkOutput("scoreboard_empty", 32'(sbQ.size()), 32'd0);
    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
